// File: rtl/dcm_speed_ctrl.sv
// dcm_speed_ctrl: speed-level configuration controller for the programmable clock divider.
//
// Arbitrates up/down/load requests, keeps the current level (0..7), drives the divider's
// prog_in/update pair and confirms every change against the divider's prog_out readback.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   up        in   pulse: request level + 1 (saturating)
//   down      in   pulse: request level - 1 (saturating)
//   load      in   pulse: request level = load_val (highest priority)
//   load_val  in   [2:0] level for load
//   dcm_prog  in   [2:0] readback from the divider
//   prog_sel  out  [2:0] level being or last programmed
//   update    out  divider update strobe, high HOLD_CYCLES cycles per transaction
//   busy      out  transaction in progress
//   done      out  pulse: transaction confirmed by readback
//   err       out  sticky readback timeout, cleared by the next confirmed transaction
//   drop      out  pulse: request discarded (busy, saturated or conflicting)
module dcm_speed_ctrl #(
   parameter logic [2:0]  DEFAULT_LEVEL = 3'd0,
   parameter int unsigned HOLD_CYCLES   = 2,
   parameter int unsigned ACK_TIMEOUT   = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       up,
   input  logic       down,
   input  logic       load,
   input  logic [2:0] load_val,
   input  logic [2:0] dcm_prog,
   output logic [2:0] prog_sel,
   output logic       update,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       drop
);

   localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned AckW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
   localparam logic [AckW-1:0]  AckLast  = AckW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {StInit, StIdle, StApply, StWaitAck} state_e;

   state_e           state_q, state_d;
   logic [2:0]       prog_sel_q, prog_sel_d;
   logic             update_q, update_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             drop_q, drop_d;
   logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
   logic [AckW-1:0]  ack_cnt_q, ack_cnt_d;

   logic             any_req;
   logic             accept;
   logic [2:0]       target;

   assign any_req = up | down | load;

   // Request arbitration in IDLE: load wins, otherwise exactly one of up/down, saturating.
   always_comb begin
      accept = 1'b0;
      target = prog_sel_q;
      if (load) begin
         accept = 1'b1;
         target = load_val;
      end else if (up && !down) begin
         if (prog_sel_q != 3'd7) begin
            accept = 1'b1;
            target = prog_sel_q + 3'd1;
         end
      end else if (down && !up) begin
         if (prog_sel_q != 3'd0) begin
            accept = 1'b1;
            target = prog_sel_q - 3'd1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      prog_sel_d = prog_sel_q;
      update_d   = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      drop_d     = 1'b0;
      hold_cnt_d = hold_cnt_q;
      ack_cnt_d  = ack_cnt_q;

      case (state_q)
         StInit: begin
            drop_d     = any_req;
            state_d    = StApply;
            prog_sel_d = DEFAULT_LEVEL;
            update_d   = 1'b1;
            busy_d     = 1'b1;
            hold_cnt_d = '0;
         end
         StIdle: begin
            if (accept) begin
               state_d    = StApply;
               prog_sel_d = target;
               update_d   = 1'b1;
               busy_d     = 1'b1;
               hold_cnt_d = '0;
            end else begin
               drop_d = any_req;
            end
         end
         StApply: begin
            drop_d = any_req;
            if (hold_cnt_q == HoldLast) begin
               state_d   = StWaitAck;
               ack_cnt_d = '0;
            end else begin
               update_d   = 1'b1;
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         StWaitAck: begin
            drop_d = any_req;
            if (dcm_prog == prog_sel_q) begin
               state_d = StIdle;
               done_d  = 1'b1;
               err_d   = 1'b0;
               busy_d  = 1'b0;
            end else if (ack_cnt_q == AckLast) begin
               // prog_sel keeps the attempted level so software can see what failed.
               state_d = StIdle;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end else begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StInit;
         prog_sel_q <= 3'd0;
         update_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         drop_q     <= 1'b0;
         hold_cnt_q <= '0;
         ack_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         prog_sel_q <= prog_sel_d;
         update_q   <= update_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         drop_q     <= drop_d;
         hold_cnt_q <= hold_cnt_d;
         ack_cnt_q  <= ack_cnt_d;
      end
   end

   assign prog_sel = prog_sel_q;
   assign update   = update_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign drop     = drop_q;

endmodule

// File: tb/tb_dcm_speed_ctrl.sv
// Directed self-checking bench for dcm_speed_ctrl (default parameters).
module tb_dcm_speed_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       up, down, load;
   logic [2:0] load_val;
   logic [2:0] dcm_prog;
   logic [2:0] prog_sel;
   logic       update, busy, done, err, drop;

   logic       follow;
   int         checks = 0;
   int         errors = 0;

   dcm_speed_ctrl dut (
      .clock    (clock),
      .reset    (reset),
      .up       (up),
      .down     (down),
      .load     (load),
      .load_val (load_val),
      .dcm_prog (dcm_prog),
      .prog_sel (prog_sel),
      .update   (update),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .drop     (drop)
   );

   always #5 clock = ~clock;

   // Divider model: prog_out tracks prog_in one cycle late when follow is set.
   initial begin
      forever begin
         @(posedge clock);
         if (follow) dcm_prog <= prog_sel;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the done pulse; leaves the bench in the done cycle.
   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (done === 1'b1) seen = 1'b1;
      end
      chk(tag, {7'd0, seen}, 8'd1);
   endtask

   task automatic do_load(input logic [2:0] v, input string tag);
      load     = 1'b1;
      load_val = v;
      tick();
      load = 1'b0;
      wait_done(tag);
      chk({tag, "_lvl"}, {5'd0, prog_sel}, {5'd0, v});
   endtask

   initial begin
      reset    = 1'b0;
      up       = 1'b0;
      down     = 1'b0;
      load     = 1'b0;
      load_val = 3'd0;
      dcm_prog = 3'd0;
      follow   = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_prog_sel", {5'd0, prog_sel}, 8'd0);
      chk("rst_update", {7'd0, update}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_err", {7'd0, err}, 8'd0);
      chk("rst_drop", {7'd0, drop}, 8'd0);

      // Release; an up during INIT is dropped while DEFAULT_LEVEL is programmed
      reset = 1'b1;
      up    = 1'b1;
      tick();
      up = 1'b0;
      chk("init_drop", {7'd0, drop}, 8'd1);
      chk("init_update1", {7'd0, update}, 8'd1);
      chk("init_busy", {7'd0, busy}, 8'd1);
      chk("init_prog_sel", {5'd0, prog_sel}, 8'd0);
      tick();
      chk("init_update2", {7'd0, update}, 8'd1);
      chk("init_drop_clr", {7'd0, drop}, 8'd0);
      tick();
      chk("init_update_off", {7'd0, update}, 8'd0);
      chk("init_busy_wait", {7'd0, busy}, 8'd1);
      tick();
      chk("init_done", {7'd0, done}, 8'd1);
      chk("init_busy_off", {7'd0, busy}, 8'd0);
      tick();
      chk("init_done_pulse", {7'd0, done}, 8'd0);

      // Up from level 3
      do_load(3'd3, "ld3");
      up = 1'b1;
      tick();
      up = 1'b0;
      chk("up_prog_sel", {5'd0, prog_sel}, 8'd4);
      chk("up_update", {7'd0, update}, 8'd1);
      chk("up_busy", {7'd0, busy}, 8'd1);
      tick();
      chk("up_update2", {7'd0, update}, 8'd1);
      tick();
      chk("up_update_off", {7'd0, update}, 8'd0);
      tick();
      chk("up_done", {7'd0, done}, 8'd1);
      chk("up_err", {7'd0, err}, 8'd0);
      chk("up_busy_off", {7'd0, busy}, 8'd0);

      // Saturation at 7 and 0
      do_load(3'd7, "ld7");
      up = 1'b1;
      tick();
      up = 1'b0;
      chk("sat7_drop", {7'd0, drop}, 8'd1);
      chk("sat7_update", {7'd0, update}, 8'd0);
      chk("sat7_busy", {7'd0, busy}, 8'd0);
      chk("sat7_prog_sel", {5'd0, prog_sel}, 8'd7);
      tick();
      chk("sat7_drop_pulse", {7'd0, drop}, 8'd0);
      chk("sat7_prog_sel2", {5'd0, prog_sel}, 8'd7);
      do_load(3'd0, "ld0");
      down = 1'b1;
      tick();
      down = 1'b0;
      chk("sat0_drop", {7'd0, drop}, 8'd1);
      chk("sat0_update", {7'd0, update}, 8'd0);
      chk("sat0_prog_sel", {5'd0, prog_sel}, 8'd0);

      // Conflicting up+down in IDLE
      do_load(3'd4, "ld4");
      up   = 1'b1;
      down = 1'b1;
      tick();
      up   = 1'b0;
      down = 1'b0;
      chk("conf_drop", {7'd0, drop}, 8'd1);
      chk("conf_update", {7'd0, update}, 8'd0);
      chk("conf_prog_sel", {5'd0, prog_sel}, 8'd4);

      // Load beats up; up while busy is dropped
      do_load(3'd2, "ld2");
      load     = 1'b1;
      load_val = 3'd6;
      up       = 1'b1;
      tick();
      load = 1'b0;
      chk("prio_prog_sel", {5'd0, prog_sel}, 8'd6);
      chk("prio_update", {7'd0, update}, 8'd1);
      tick();
      up = 1'b0;
      chk("busy_drop", {7'd0, drop}, 8'd1);
      wait_done("prio_done");
      chk("prio_final", {5'd0, prog_sel}, 8'd6);

      // Readback timeout while programming 5
      follow   = 1'b0;
      dcm_prog = 3'd0;
      load     = 1'b1;
      load_val = 3'd5;
      tick();
      load = 1'b0;
      for (int i = 0; i < 17; i++) tick();
      chk("to_busy_last", {7'd0, busy}, 8'd1);
      chk("to_err_early", {7'd0, err}, 8'd0);
      tick();
      chk("to_err", {7'd0, err}, 8'd1);
      chk("to_busy_off", {7'd0, busy}, 8'd0);
      chk("to_no_done", {7'd0, done}, 8'd0);
      chk("to_prog_sel", {5'd0, prog_sel}, 8'd5);
      follow = 1'b1;
      tick();
      load     = 1'b1;
      load_val = 3'd5;
      tick();
      load = 1'b0;
      chk("to_err_sticky", {7'd0, err}, 8'd1);
      wait_done("recov_done");
      chk("recov_err_clr", {7'd0, err}, 8'd0);

      // Asynchronous reset during APPLY at level 5
      load     = 1'b1;
      load_val = 3'd5;
      tick();
      load = 1'b0;
      chk("ar_update_pre", {7'd0, update}, 8'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_update", {7'd0, update}, 8'd0);
      chk("ar_busy", {7'd0, busy}, 8'd0);
      chk("ar_prog_sel", {5'd0, prog_sel}, 8'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("ar_init_update", {7'd0, update}, 8'd1);
      chk("ar_init_busy", {7'd0, busy}, 8'd1);
      chk("ar_init_prog_sel", {5'd0, prog_sel}, 8'd0);
      wait_done("ar_done");
      chk("ar_final", {5'd0, prog_sel}, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcm_speed_ctrl.md
# dcm_speed_ctrl

Configuration controller for the programmable clock divider (`dcm`). It arbitrates speed-change requests from the front-panel buttons (up/down) and a direct-load port, keeps the current speed level (0–7), and drives the divider's `prog_in`/`update` pair. It confirms each change against the divider's `prog_out` feedback, flagging an error if the readback does not match within a bounded time. It sits between the debounced input logic and `dcm`, in the system clock domain.

## Interface

- `DEFAULT_LEVEL`, 3'd0: level programmed automatically after reset release.
- `HOLD_CYCLES`, 2: cycles `update` stays high per transaction (≥1).
- `ACK_TIMEOUT`, 16: maximum cycles to wait for readback match (≥1).

- `clock` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `up` in 1: single-cycle pulse; request level+1.
- `down` in 1: single-cycle pulse; request level−1.
- `load` in 1: single-cycle pulse; request level = `load_val`.
- `load_val` in 3: level for `load`.
- `dcm_prog` in 3: readback from `dcm.prog_out`.
- `prog_sel` out 3: to `dcm.prog_in`; level being or last programmed.
- `update` out 1: to `dcm.update`.
- `busy` out 1: transaction in progress; new requests are not accepted.
- `done` out 1: one-cycle pulse on a confirmed transaction.
- `err` out 1: sticky timeout flag; cleared by the next confirmed transaction.
- `drop` out 1: one-cycle pulse when a request is discarded (busy, saturated or conflicting).

## Operation

- States: INIT, IDLE, APPLY, WAIT_ACK.
- Reset (`reset`=0): state INIT, `prog_sel`=0, `update`=0, `busy`=0, `done`=0, `err`=0, `drop`=0, counters 0.
- INIT: in the first cycle after reset release, load target=`DEFAULT_LEVEL` and go to APPLY. No request is accepted in INIT; any request is dropped.
- IDLE: requests are evaluated each cycle, with priority `load` > (`up` xor `down`).
  - `up` and `down` in the same cycle without `load`: drop.
  - `up` at level 7 or `down` at level 0: saturate. Drop; no transaction; `prog_sel` unchanged.
  - `load` with `load_val`==`prog_sel`: a transaction is still issued (forced re-sync).
  - On an accepted request: target latched, go to APPLY.
- APPLY: `prog_sel`=target, `update`=1 for exactly `HOLD_CYCLES` cycles, then WAIT_ACK.
- WAIT_ACK: `update`=0. Compare `dcm_prog`==`prog_sel` every cycle.
  - On match: `done` pulses, `err` clears, go to IDLE.
  - If no match within `ACK_TIMEOUT` cycles: `err`=1, no `done`, go to IDLE. `prog_sel` keeps the attempted value.
- Any request arriving in a state other than IDLE: `drop` pulses, the request is ignored, and there is no queueing.
- Level arithmetic is 3-bit with saturation; it never wraps.

## Timing

- A request sampled in IDLE at edge N gives: state APPLY, `busy`=1, `prog_sel`=new, `update`=1 from cycle N+1.
- `update` is high during cycles N+1 … N+`HOLD_CYCLES`. `prog_sel` is stable from N+1 through the end of the transaction and beyond.
- WAIT_ACK starts at cycle N+`HOLD_CYCLES`+1. The readback is checked starting in that cycle.
- A match in WAIT_ACK cycle M gives `done`=1 in cycle M+1, and `busy`=0 in cycle M+1.
- Timeout: the last check is WAIT_ACK cycle `ACK_TIMEOUT`. `err`=1 and `busy`=0 in the following cycle.
- Minimum request-to-request spacing is `HOLD_CYCLES`+2 cycles (immediate readback match).
- `drop` is registered: it goes high in the cycle after the offending request and lasts one cycle.
- `reset` assertion mid-transaction: all outputs return to reset values immediately and asynchronously. After release, INIT reprograms `DEFAULT_LEVEL`.

## Test plan

- Reset release, with `dcm_prog` following `prog_sel` one cycle late: `update` high 2 cycles with `prog_sel`=0; `done` pulses; `busy` returns to 0.
- From level 3, `up` pulse: `prog_sel`=4 and `update`=1 in the next cycle. With a matching `dcm_prog`, `done` pulses and `err`=0.
- At level 7, `up`: `drop` pulses, no `update`, `prog_sel` stays 7. At level 0, `down`: same behaviour, level stays 0.
- `load`=1 with `load_val`=6 and `up`=1 in the same cycle, from level 2: target 6 is applied. A second `up` during `busy` → `drop`, and the final level is 6.
- `dcm_prog` held at 0 while programming 5: after 16 WAIT_ACK cycles, `err`=1 with no `done`. The next successful `load` with 5 clears `err` and pulses `done`.
- `reset` pulled low during APPLY at level 5: `update`, `busy`, `prog_sel` go to 0 immediately. After release, INIT programs `DEFAULT_LEVEL`.
